// File: rtl/mem_bank_sequencer.sv
// rtl/mem_bank_sequencer.sv - fill-then-arbitrate controller for one single-port memory bank
module mem_bank_sequencer #(
  parameter int DEPTH      = 1718,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  reinit,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  init_done
);

  typedef enum logic {S_FILL, S_RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                  r_ptr, w_ptr_nxt;    // 1 = requester 1 wins a tie
  logic                  r_rvalid0, r_rvalid1;
  logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;
  logic                  w_gnt0, w_gnt1;

  // Outputs are gated by reset_n so the bank is idle the instant reset asserts.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (reset_n) begin
      case (r_state)
        S_FILL: begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = r_cnt;
          mem_wdata = DATA_WIDTH'(r_cnt);
          if (r_cnt == LAST_ADDR) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_RUN: begin
          w_gnt0 = req0 & (~req1 | ~r_ptr);
          w_gnt1 = req1 & ~w_gnt0;
          if (w_gnt0) begin
            mem_en    = 1'b1;
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
            w_ptr_nxt = 1'b1;
          end else if (w_gnt1) begin
            mem_en    = 1'b1;
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
            w_ptr_nxt = 1'b0;
          end
          if (reinit) begin
            w_state_nxt = S_FILL;
            w_cnt_nxt   = '0;
          end
        end
        default: w_state_nxt = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_FILL;
      r_cnt     <= '0;
      r_ptr     <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_rvalid0 <= w_gnt0 & ~we0;
      r_rvalid1 <= w_gnt1 & ~we1;
      if (r_rvalid0) r_rdata0 <= mem_rdata;
      if (r_rvalid1) r_rdata1 <= mem_rdata;
    end
  end

  // Bank data passes straight through in the return cycle, then is held.
  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata0    = r_rvalid0 ? mem_rdata : r_rdata0;
  assign rdata1    = r_rvalid1 ? mem_rdata : r_rdata1;
  assign init_done = (r_state == S_RUN);

endmodule

// File: tb/tb_mem_bank_sequencer.sv
// tb/tb_mem_bank_sequencer.sv - directed and randomized bench with a transaction-level model
module tb_mem_bank_sequencer;
  localparam int DEPTH = 1718;
  localparam int AW    = 11;
  localparam int DW    = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, reinit, req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, init_done;
  logic [DW-1:0] rdata0, rdata1, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [AW-1:0] mem_addr;

  mem_bank_sequencer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .reinit(reinit),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .init_done(init_done)
  );

  // Single-port bank with one-cycle registered read.
  logic [DW-1:0] bank [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bank[mem_addr] <= mem_wdata;
      else        mem_rdata      <= bank[mem_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: contents, fill progress, tie-break preference, pending reads.
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  bit            m_run, m_fav1, m_pv0, m_pv1;
  int            m_cnt;
  logic [DW-1:0] m_pd0, m_pd1, m_last0, m_last1;
  logic          obs_gnt0, obs_gnt1, obs_rv0, obs_rv1, obs_init;
  logic [DW-1:0] obs_rd0, obs_rd1;

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_fav1 = 0;
    m_pv0 = 0; m_pv1 = 0; m_last0 = '0; m_last1 = '0;
  endtask

  // One clock cycle: inputs already driven; check at negedge, advance model, return at posedge+1.
  task automatic cyc(output bit g0, output bit g1);
    @(negedge clk);
    obs_gnt0 = gnt0; obs_gnt1 = gnt1; obs_rv0 = rvalid0; obs_rv1 = rvalid1;
    obs_rd0 = rdata0; obs_rd1 = rdata1; obs_init = init_done;
    if (!m_run) begin
      g0 = 0; g1 = 0;
      chk("fill_en", 32'(mem_en), 32'd1);
      chk("fill_we", 32'(mem_we), 32'd1);
      chk("fill_addr", 32'(mem_addr), 32'(m_cnt));
      chk("fill_wdata", 32'(mem_wdata), 32'(m_cnt % (1 << DW)));
      chk("init_done_fill", 32'(init_done), 32'd0);
    end else begin
      g0 = req0 && (!req1 || !m_fav1);
      g1 = req1 && !g0;
      chk("init_done_run", 32'(init_done), 32'd1);
      chk("run_en", 32'(mem_en), 32'(g0 | g1));
      if (g0 || g1) begin
        chk("run_we", 32'(mem_we), 32'(g0 ? we0 : we1));
        chk("run_addr", 32'(mem_addr), 32'(g0 ? addr0 : addr1));
        if (g0 ? we0 : we1) chk("run_wdata", 32'(mem_wdata), 32'(g0 ? wdata0 : wdata1));
      end
    end
    chk("gnt0", 32'(gnt0), 32'(g0));
    chk("gnt1", 32'(gnt1), 32'(g1));
    if (m_pv0) m_last0 = m_pd0;
    if (m_pv1) m_last1 = m_pd1;
    chk("rvalid0", 32'(rvalid0), 32'(m_pv0));
    chk("rvalid1", 32'(rvalid1), 32'(m_pv1));
    chk("rdata0", 32'(rdata0), 32'(m_last0));
    chk("rdata1", 32'(rdata1), 32'(m_last1));
    m_pv0 = g0 && !we0;
    m_pv1 = g1 && !we1;
    if (m_pv0) m_pd0 = ref_mem[addr0];
    if (m_pv1) m_pd1 = ref_mem[addr1];
    if (!m_run) begin
      ref_mem[m_cnt] = DW'(m_cnt);
      m_cnt++;
      if (m_cnt == DEPTH) begin m_run = 1; m_cnt = 0; end
    end else begin
      if (g0 && we0) ref_mem[addr0] = wdata0;
      if (g1 && we1) ref_mem[addr1] = wdata1;
      if (g0) m_fav1 = 1;
      else if (g1) m_fav1 = 0;
      if (reinit) begin m_run = 0; m_cnt = 0; end
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'({gnt0, gnt1}), 32'd0);
    chk({tag, "_rvalid"}, 32'({rvalid0, rvalid1}), 32'd0);
    chk({tag, "_rdata0"}, 32'(rdata0), 32'd0);
    chk({tag, "_rdata1"}, 32'(rdata1), 32'd0);
    chk({tag, "_mem_ctl"}, 32'({mem_en, mem_we}), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_init_done"}, 32'(init_done), 32'd0);
  endtask

  // Called at posedge+1; releases reset so the following edge is fill cycle 0.
  task automatic apply_reset(input int cycles, input bit immediate);
    reset_n = 1'b0;
    if (immediate) begin #1; chk_zero("rst_now"); end
    repeat (cycles) @(posedge clk);
    #1;
    chk_zero("rst_hold");
    model_reset();
    reset_n = 1'b1;
  endtask

  bit g0, g1, new0, new1;
  int n0, n1;

  initial begin
    reset_n = 1'b0; reinit = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = AW'(DEPTH - 1); wdata0 = '0;
    req1 = 1'b1; we1 = 1'b0; addr1 = '0;             wdata1 = '0;
    model_reset();
    apply_reset(3, 1'b0);

    // Fill with both requests pending, then first grants.
    repeat (DEPTH) cyc(g0, g1);
    cyc(g0, g1);
    chk("tp_first_gnt0", 32'({obs_gnt0, obs_gnt1}), 32'b10);
    chk("tp_init_rise", 32'(obs_init), 32'd1);
    req0 = 1'b0;
    cyc(g0, g1);
    chk("tp_second_gnt1", 32'({obs_gnt0, obs_gnt1}), 32'b01);
    chk("tp_rdata_1717", 32'(obs_rd0), 32'h006B5);

    // Continuous dual reads alternate 0,1,0,...
    req0 = 1'b1; addr0 = AW'(175); req1 = 1'b1; addr1 = AW'(44);
    n0 = 0; n1 = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(g0, g1);
      n0 += int'(obs_gnt0); n1 += int'(obs_gnt1);
      chk("tp_alt_gnt0", 32'(obs_gnt0), 32'((k % 2) == 0));
      if (k > 0) chk("tp_alt_rdata", 32'(obs_gnt0 ? obs_rd1 : obs_rd0), 32'(obs_gnt0 ? 44 : 175));
    end
    chk("tp_alt_count", 32'({n0[7:0], n1[7:0]}), 32'h0303);
    req0 = 1'b0; req1 = 1'b0;
    cyc(g0, g1);
    chk("tp_alt_last", 32'({obs_rv1, obs_rd1}), 32'({1'b1, 18'd44}));

    // Write then immediate read of the same address from the other side.
    req0 = 1'b1; we0 = 1'b1; addr0 = AW'(44); wdata0 = 18'h3FFFF;
    cyc(g0, g1);
    req0 = 1'b0; we0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = AW'(44);
    cyc(g0, g1);
    req1 = 1'b0;
    cyc(g0, g1);
    chk("tp_wr_rd_rvalid", 32'({obs_rv0, obs_rv1}), 32'b01);
    chk("tp_wr_rd_data", 32'(obs_rd1), 32'h3FFFF);

    // reinit coincident with a granted read.
    req0 = 1'b1; addr0 = AW'(10); reinit = 1'b1;
    cyc(g0, g1);
    chk("tp_reinit_gnt", 32'(obs_gnt0), 32'd1);
    reinit = 1'b0; req0 = 1'b0;
    cyc(g0, g1);
    chk("tp_reinit_rdata", 32'({obs_rv0, obs_rd0}), 32'({1'b1, 18'd10}));
    chk("tp_reinit_done_low", 32'(obs_init), 32'd0);
    repeat (DEPTH - 1) cyc(g0, g1);
    cyc(g0, g1);
    chk("tp_refill_done", 32'(obs_init), 32'd1);

    // Randomized traffic: requests persist until granted.
    new0 = 1; new1 = 1;
    for (int k = 0; k < 600; k++) begin
      if (new0) begin
        req0 = ($urandom_range(0, 3) != 0); we0 = 1'($urandom_range(0, 1));
        addr0 = AW'($urandom_range(0, DEPTH - 1)); wdata0 = DW'($urandom);
      end
      if (new1) begin
        req1 = ($urandom_range(0, 3) != 0); we1 = 1'($urandom_range(0, 1));
        addr1 = AW'($urandom_range(0, DEPTH - 1)); wdata1 = DW'($urandom);
      end
      cyc(g0, g1);
      new0 = g0 || !req0;
      new1 = g1 || !req1;
    end

    // Reset right after a read grant cancels the pending rvalid.
    req0 = 1'b1; we0 = 1'b0; addr0 = AW'(5); req1 = 1'b0;
    cyc(g0, g1);
    req0 = 1'b0;
    apply_reset(2, 1'b1);
    repeat (DEPTH) cyc(g0, g1);

    // Reset mid-fill at address 500, then full refill.
    reinit = 1'b1;
    cyc(g0, g1);
    reinit = 1'b0;
    repeat (500) cyc(g0, g1);
    chk("tp_midfill_addr", 32'(mem_addr), 32'd500);
    apply_reset(2, 1'b1);
    repeat (DEPTH) cyc(g0, g1);
    req0 = 1'b1; we0 = 1'b0; addr0 = AW'(DEPTH - 1);
    cyc(g0, g1);
    chk("tp_midfill_done", 32'({obs_init, obs_gnt0}), 32'b11);
    req0 = 1'b0;
    cyc(g0, g1);
    chk("tp_midfill_rdata", 32'(obs_rd0), 32'h006B5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_bank_sequencer.md
# mem_bank_sequencer

Controller for one single-port synchronous memory bank (e.g. an 18-bit × 1718 bank). After reset it runs a fill sequence that writes each location with its own address, then shares the bank between two requesters with round-robin arbitration, one access per cycle. Sits between the bank and its users: testbench transactors or DUT-side agents.

## Interface
- DEPTH, 1718: number of words; addresses 0..DEPTH-1
- ADDR_WIDTH, 11: address width; 2^ADDR_WIDTH >= DEPTH
- DATA_WIDTH, 18: word width
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- reinit  in  1  single-cycle pulse; reruns the fill sequence
- req0 / req1  in  1  access request; held until granted
- we0 / we1  in  1  1 = write, 0 = read; qualified by req
- addr0 / addr1  in  ADDR_WIDTH  access address
- wdata0 / wdata1  in  DATA_WIDTH  write data
- gnt0 / gnt1  out  1  access issued this cycle
- rvalid0 / rvalid1  out  1  read data valid, one cycle after grant
- rdata0 / rdata1  out  DATA_WIDTH  read data; valid only with rvalid
- mem_en  out  1  bank enable
- mem_we  out  1  bank write enable
- mem_addr  out  ADDR_WIDTH  bank address
- mem_wdata  out  DATA_WIDTH  bank write data
- mem_rdata  in  DATA_WIDTH  bank read data, one cycle after mem_en with mem_we=0
- init_done  out  1  high once the fill completes; low during fill

## Operation
- States: FILL, RUN. Reset enters FILL with fill counter = 0.
- FILL: each cycle drive mem_en=1, mem_we=1, mem_addr=counter, mem_wdata=counter zero-extended or truncated to DATA_WIDTH (value = counter mod 2^DATA_WIDTH). Increment counter. After writing address DEPTH-1, go to RUN and set init_done=1. gnt0 and gnt1 are 0 throughout FILL; requests wait.
- RUN: gnt and mem_* are combinational from req, state and the priority pointer. If only one req is high, grant it. If both are high, grant the side the pointer favours. After any grant the pointer flips to favour the other side. Grant drives mem_en=1, mem_we=weN, mem_addr=addrN, mem_wdata=wdataN. With no req, mem_en=0.
- Reads: a granted read sets rvalidN=1 and rdataN=mem_rdata in the following cycle. Non-granted rdata holds its last value.
- reinit in RUN: next cycle enters FILL with counter=0 and init_done=0. A grant in the same cycle as reinit is still issued. Its read rvalid still returns. reinit during FILL is ignored.
- Writes by the requesters go straight to the bank; there is no read-modify-write and no hazard logic. A read of an address written in the previous cycle returns the new data, because the bank is single-port and accesses are serialized.

## Timing
- Reset (reset_n low, asynchronous): gnt0=gnt1=0, rvalid0=rvalid1=0, rdata0=rdata1=0, mem_en=mem_we=0, mem_addr=0, mem_wdata=0, init_done=0. Pointer favours requester 0. Any pending rvalid is cancelled.
- Cycle 0 = first rising edge with reset_n high. Fill writes occupy cycles 0..DEPTH-1. init_done=1 from cycle DEPTH. The first grant is possible in cycle DEPTH.
- Grant latency: 0 cycles, granted in the same cycle req is seen in RUN. Read latency: 1 cycle from grant to rvalid.
- Throughput: one access per cycle, back-to-back. Under continuous dual requests the grants alternate 0,1,0,1…
- The requester drops req or presents a new transaction in the cycle after gnt. A req held high after gnt is a new request.
- Reset asserted mid-fill or mid-read aborts immediately. The fill restarts from address 0 after release.

## Test plan
- Reset release with no requests -> 1718 consecutive writes with mem_addr=mem_wdata=0..1717; init_done rises in cycle 1718; reading address 1717 returns 0x006B5.
- req0 and req1 held from cycle 0 -> no gnt until cycle 1718, then gnt0 in cycle 1718, gnt1 in cycle 1719, alternating.
- RUN, req0 writes addr 44 = 0x3FFFF, then the next cycle req1 reads addr 44 -> rvalid1 one cycle later with rdata1=0x3FFFF; rvalid0 stays 0.
- Both requesters issue continuous reads of addresses 175 and 44 for 6 cycles -> 3 grants each, alternating; each rvalid follows its grant by 1 cycle with data 175 and 44.
- reinit pulsed together with a granted read of addr 10 -> rvalid returns 10; init_done falls the next cycle; a full fill repeats.
- reset_n dropped at fill address 500 -> all outputs 0 immediately; after release the fill restarts at address 0 and completes 1718 cycles later.
